i2c_txn_sched: RTL

- Transaction scheduler sharing one byte-level I2C master engine between N_REQ requesters.
- Round-robin arbitration picks one requester at a time.
- Each granted transaction is sequenced as START, address byte, LEN data bytes (write or read), then STOP.
- Sits between client blocks (sensor pollers, config loaders) and the I2C bit engine that drives SCL/SDA.

---
 rtl/i2c_txn_sched_if.sv | 21 ++
 rtl/i2c_txn_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sched_if.sv
// rtl/i2c_txn_sched_if.sv - command/response bus between the scheduler and the I2C byte engine
interface i2c_txn_sched_if;
    logic [1:0] eng_cmd;
    logic [7:0] eng_cmd_data;
    logic       eng_last;
    logic       eng_cmd_valid;
    logic       eng_cmd_ready;
    logic       eng_rsp_valid;
    logic [7:0] eng_rsp_data;
    logic       eng_rsp_nack;

    modport master (
        output eng_cmd, eng_cmd_data, eng_last, eng_cmd_valid,
        input  eng_cmd_ready, eng_rsp_valid, eng_rsp_data, eng_rsp_nack
    );

    modport slave (
        input  eng_cmd, eng_cmd_data, eng_last, eng_cmd_valid,
        output eng_cmd_ready, eng_rsp_valid, eng_rsp_data, eng_rsp_nack
    );
endinterface

// File: rtl/i2c_txn_sched.sv
// rtl/i2c_txn_sched.sv - round-robin scheduler sequencing START/ADDR/DATA/STOP onto one I2C byte engine
module i2c_txn_sched #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [7*N_REQ-1:0]     req_addr,
    input  logic [N_REQ-1:0]       req_rw,
    input  logic [LEN_W*N_REQ-1:0] req_len,
    input  logic [8*N_REQ-1:0]     req_wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       wdata_pop,
    output logic [7:0]             rd_data,
    output logic [N_REQ-1:0]       rd_valid,
    output logic [N_REQ-1:0]       done,
    output logic                   nack,
    i2c_txn_sched_if.master        eng
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_CMD, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {P_START, P_ADDR, P_DATA, P_STOP} phase_t;

    state_t           state, state_nx;
    phase_t           phase, phase_nx;
    logic [PW-1:0]    rr, rr_nx;
    logic [6:0]       addr, addr_nx;
    logic             rw, rw_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [N_REQ-1:0] grant_nx;
    logic             nack_nx;
    logic [7:0]       rd_data_nx;
    logic             rd_pulse, rd_pulse_nx;

    logic [6:0]       addr_a  [N_REQ];
    logic [LEN_W-1:0] len_a   [N_REQ];
    logic [7:0]       wdata_a [N_REQ];
    logic             found;
    logic [PW-1:0]    win, cand;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_a[i]  = req_addr[7*i +: 7];
            len_a[i]   = req_len[LEN_W*i +: LEN_W];
            wdata_a[i] = req_wdata[8*i +: 8];
        end
    end

    // First asserted request after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(rr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            phase    <= P_START;
            rr       <= PW'(N_REQ - 1);
            addr     <= '0;
            rw       <= 1'b0;
            cnt      <= '0;
            grant    <= '0;
            nack     <= 1'b0;
            rd_data  <= '0;
            rd_pulse <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            rr       <= rr_nx;
            addr     <= addr_nx;
            rw       <= rw_nx;
            cnt      <= cnt_nx;
            grant    <= grant_nx;
            nack     <= nack_nx;
            rd_data  <= rd_data_nx;
            rd_pulse <= rd_pulse_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        rr_nx       = rr;
        addr_nx     = addr;
        rw_nx       = rw;
        cnt_nx      = cnt;
        grant_nx    = grant;
        nack_nx     = nack;
        rd_data_nx  = rd_data;
        rd_pulse_nx = 1'b0;

        eng.eng_cmd_valid = (state == S_CMD);
        eng.eng_cmd       = 2'b00;
        eng.eng_cmd_data  = 8'h00;
        eng.eng_last      = 1'b0;
        wdata_pop         = '0;
        done              = (state == S_DONE) ? grant : '0;
        rd_valid          = rd_pulse ? grant : '0;

        if (state == S_CMD) begin
            case (phase)
                P_START: eng.eng_cmd = 2'b00;
                P_ADDR: begin
                    eng.eng_cmd      = 2'b01;
                    eng.eng_cmd_data = {addr, rw};
                end
                P_DATA: begin
                    if (rw) begin
                        eng.eng_cmd  = 2'b10;
                        eng.eng_last = (cnt == LEN_W'(1));
                    end else begin
                        eng.eng_cmd      = 2'b01;
                        eng.eng_cmd_data = wdata_a[rr];
                        wdata_pop        = eng.eng_cmd_ready ? grant : '0;
                    end
                end
                default: eng.eng_cmd = 2'b11;
            endcase
        end

        case (state)
            S_IDLE: if (|req_valid) state_nx = S_ARB;
            S_ARB: begin
                if (found) begin
                    addr_nx  = addr_a[win];
                    rw_nx    = req_rw[win];
                    cnt_nx   = len_a[win];
                    rr_nx    = win;
                    grant_nx = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    phase_nx = P_START;
                    state_nx = S_CMD;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CMD: if (eng.eng_cmd_ready) state_nx = S_WAIT;
            S_WAIT: begin
                if (eng.eng_rsp_valid) begin
                    state_nx = S_CMD;
                    case (phase)
                        P_START: phase_nx = P_ADDR;
                        P_ADDR: begin
                            if (eng.eng_rsp_nack) begin
                                nack_nx  = 1'b1;
                                phase_nx = P_STOP;
                            end else if (cnt == '0) begin
                                phase_nx = P_STOP;
                            end else begin
                                phase_nx = P_DATA;
                            end
                        end
                        P_DATA: begin
                            // A NACKed write abandons the remaining bytes; reads ignore the flag.
                            if (!rw && eng.eng_rsp_nack) begin
                                nack_nx  = 1'b1;
                                phase_nx = P_STOP;
                            end else begin
                                if (rw) begin
                                    rd_data_nx  = eng.eng_rsp_data;
                                    rd_pulse_nx = 1'b1;
                                end
                                cnt_nx = cnt - LEN_W'(1);
                                if (cnt == LEN_W'(1)) phase_nx = P_STOP;
                            end
                        end
                        default: state_nx = S_DONE;
                    endcase
                end
            end
            S_DONE: begin
                grant_nx = '0;
                nack_nx  = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule
